// File: rtl/risc16_prog_loader.sv
// Streaming program/data loader: parses a tagged frame, writes payload words into
// the selected memory and validates a trailing additive checksum.
module risc16_prog_loader #(
  parameter int         WORD_LENGTH  = 16,
  parameter int         PROGRAM_SIZE = 20,
  parameter int         DATA_SIZE    = 20,
  parameter logic [7:0] MAGIC        = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WORD_LENGTH-1:0] in_data,
  output logic                   in_ready,
  input  logic                   abort,
  output logic                   mem_we,
  output logic                   mem_sel,
  output logic [15:0]            mem_addr,
  output logic [WORD_LENGTH-1:0] mem_wdata,
  output logic                   pen,
  output logic                   cpu_rst,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             err_code
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] HDR_ADDR = 3'd1;
  localparam logic [2:0] HDR_LEN  = 3'd2;
  localparam logic [2:0] LOAD     = 3'd3;
  localparam logic [2:0] CHECK    = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;
  localparam logic [2:0] ERR      = 3'd6;

  logic [2:0]             state_q, state_d;
  logic                   tgt_q, tgt_d;
  logic [15:0]            addr_q, addr_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [WORD_LENGTH-1:0] csum_q, csum_d;
  logic                   pen_q, pen_d;
  logic                   cpu_rst_q, cpu_rst_d;
  logic [1:0]             err_code_q, err_code_d;
  logic                   mem_we_q, mem_we_d;
  logic                   mem_sel_q, mem_sel_d;
  logic [15:0]            mem_addr_q, mem_addr_d;
  logic [WORD_LENGTH-1:0] mem_wdata_q, mem_wdata_d;

  logic        xfer;
  logic [16:0] end_addr, mem_size;

  assign in_ready = (state_q != DONE) && (state_q != ERR);
  assign xfer     = in_valid && in_ready;
  // 17-bit sum so a start near 0xFFFF cannot wrap past the range check
  assign end_addr = {1'b0, addr_q} + {1'b0, in_data[15:0]};
  assign mem_size = tgt_q ? 17'(DATA_SIZE) : 17'(PROGRAM_SIZE);

  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    csum_d      = csum_q;
    pen_d       = pen_q;
    err_code_d  = err_code_q;
    mem_we_d    = 1'b0;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      pen_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (xfer) begin
          if (in_data[15:8] == MAGIC) begin
            tgt_d      = in_data[0];
            err_code_d = 2'd0;
            csum_d     = '0;
            pen_d      = 1'b1;
            state_d    = HDR_ADDR;
          end else begin
            err_code_d = 2'd1;
            state_d    = ERR;
          end
        end
        HDR_ADDR: if (xfer) begin
          addr_d  = in_data[15:0];
          state_d = HDR_LEN;
        end
        HDR_LEN: if (xfer) begin
          if (in_data[15:0] == 16'd0 || end_addr > mem_size) begin
            err_code_d = 2'd2;
            state_d    = ERR;
          end else begin
            cnt_d   = in_data[15:0];
            state_d = LOAD;
          end
        end
        LOAD: if (xfer) begin
          mem_we_d    = 1'b1;
          mem_sel_d   = tgt_q;
          mem_addr_d  = addr_q;
          mem_wdata_d = in_data;
          addr_d      = addr_q + 16'd1;
          cnt_d       = cnt_q - 16'd1;
          csum_d      = csum_q + in_data;
          if (cnt_q == 16'd1) state_d = CHECK;
        end
        CHECK: if (xfer) begin
          if (in_data == csum_q) begin
            state_d = DONE;
          end else begin
            err_code_d = 2'd3;
            state_d    = ERR;
          end
        end
        DONE, ERR: begin
          state_d = IDLE;
          pen_d   = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
    // core hold trails pen by one cycle on release
    cpu_rst_d = pen_d | pen_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tgt_q       <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      csum_q      <= '0;
      pen_q       <= 1'b0;
      cpu_rst_q   <= 1'b0;
      err_code_q  <= 2'd0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      csum_q      <= csum_d;
      pen_q       <= pen_d;
      cpu_rst_q   <= cpu_rst_d;
      err_code_q  <= err_code_d;
      mem_we_q    <= mem_we_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_sel   = mem_sel_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pen       = pen_q;
  assign cpu_rst   = cpu_rst_q;
  assign err_code  = err_code_q;
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);

endmodule
